// File: rtl/morse_pkg.sv
// morse_pkg: shared Morse state type, ASCII constants and pattern lookup.
// Defining MORSE_DIGITS_EN adds the five-symbol digit codes 0-9 to the lookup.
package morse_pkg;
    typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_UNKNOWN = 8'h3F;
    // Returns {known, ascii}; pattern is MSB-first, dot = 0, dash = 1.
    function automatic logic [8:0] morse_lookup(input logic [2:0] len, input logic [4:0] pat);
        logic [8:0] r;
        case ({len, pat})
            {3'd2, 5'b00001}: r = {1'b1, "A"};
            {3'd4, 5'b01000}: r = {1'b1, "B"};
            {3'd4, 5'b01010}: r = {1'b1, "C"};
            {3'd3, 5'b00100}: r = {1'b1, "D"};
            {3'd1, 5'b00000}: r = {1'b1, "E"};
            {3'd4, 5'b00010}: r = {1'b1, "F"};
            {3'd3, 5'b00110}: r = {1'b1, "G"};
            {3'd4, 5'b00000}: r = {1'b1, "H"};
            {3'd2, 5'b00000}: r = {1'b1, "I"};
            {3'd4, 5'b00111}: r = {1'b1, "J"};
            {3'd3, 5'b00101}: r = {1'b1, "K"};
            {3'd4, 5'b00100}: r = {1'b1, "L"};
            {3'd2, 5'b00011}: r = {1'b1, "M"};
            {3'd2, 5'b00010}: r = {1'b1, "N"};
            {3'd3, 5'b00111}: r = {1'b1, "O"};
            {3'd4, 5'b00110}: r = {1'b1, "P"};
            {3'd4, 5'b01101}: r = {1'b1, "Q"};
            {3'd3, 5'b00010}: r = {1'b1, "R"};
            {3'd3, 5'b00000}: r = {1'b1, "S"};
            {3'd1, 5'b00001}: r = {1'b1, "T"};
            {3'd3, 5'b00001}: r = {1'b1, "U"};
            {3'd4, 5'b00001}: r = {1'b1, "V"};
            {3'd3, 5'b00011}: r = {1'b1, "W"};
            {3'd4, 5'b01001}: r = {1'b1, "X"};
            {3'd4, 5'b01011}: r = {1'b1, "Y"};
            {3'd4, 5'b01100}: r = {1'b1, "Z"};
`ifdef MORSE_DIGITS_EN
            {3'd5, 5'b11111}: r = {1'b1, "0"};
            {3'd5, 5'b01111}: r = {1'b1, "1"};
            {3'd5, 5'b00111}: r = {1'b1, "2"};
            {3'd5, 5'b00011}: r = {1'b1, "3"};
            {3'd5, 5'b00001}: r = {1'b1, "4"};
            {3'd5, 5'b00000}: r = {1'b1, "5"};
            {3'd5, 5'b10000}: r = {1'b1, "6"};
            {3'd5, 5'b11000}: r = {1'b1, "7"};
            {3'd5, 5'b11100}: r = {1'b1, "8"};
            {3'd5, 5'b11110}: r = {1'b1, "9"};
`endif
            default: r = {1'b0, CH_UNKNOWN};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/morse_decoder_if.sv
// morse_decoder_if: key level in, decoded character strobe and status out.
interface morse_decoder_if;
    logic key_in;
    logic [7:0] char_out;
    logic char_valid;
    logic err;
    logic busy;
    modport master (output key_in, input char_out, char_valid, err, busy);
    modport slave (input key_in, output char_out, char_valid, err, busy);
endinterface

// File: rtl/morse_sync.sv
// morse_sync: 2-flop synchronizer, asynchronously reset to 0.
module morse_sync (
    input logic clk,
    input logic rst,
    input logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: times key marks/spaces against UNIT_CYCLES and emits ASCII letters and word spaces.
// Digits 0-9 decode only when MORSE_DIGITS_EN is defined (see morse_pkg).
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int MAX_SYMBOLS = 5,
    localparam int CNT_W = $clog2(8*UNIT_CYCLES)+1
) (
    input logic clk,
    input logic rst,
    morse_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(2*UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_GAP = CNT_W'(5*UNIT_CYCLES);
    localparam logic [2:0] MAX_LEN = 3'(MAX_SYMBOLS);
    state_t state, state_n;
    logic key_s, ovf, ovf_n, char_valid_n, err_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [2:0] sym_len, sym_len_n;
    logic [4:0] sym_pat, sym_pat_n;
    logic [7:0] char_out_n;
    logic [8:0] look;
    logic [7:0] char_out;
    logic char_valid, err;
    morse_sync u_sync (.clk(clk), .rst(rst), .d(bus.key_in), .q(key_s));
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign look = morse_lookup(sym_len, sym_pat);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sym_len_n = sym_len;
        sym_pat_n = sym_pat;
        ovf_n = ovf;
        char_out_n = char_out;
        char_valid_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: begin
                state_n = key_s ? MARK : IDLE;
                cnt_n = key_s ? CNT_ONE : cnt;
            end
            MARK: begin
                if (key_s) cnt_n = cnt_inc;
                else begin
                    state_n = GAP;
                    cnt_n = CNT_ONE;
                    if (sym_len < MAX_LEN) begin
                        sym_pat_n = {sym_pat[3:0], cnt >= LETTER_GAP};
                        sym_len_n = sym_len + 3'd1;
                    end else ovf_n = 1'b1;
                end
            end
            GAP: begin
                // A rising key always wins over a gap threshold reached in the same cycle.
                if (key_s) begin
                    state_n = MARK;
                    cnt_n = CNT_ONE;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == LETTER_GAP && sym_len != 3'd0) begin
                        char_valid_n = 1'b1;
                        err_n = !look[8] || ovf;
                        char_out_n = err_n ? CH_UNKNOWN : look[7:0];
                        sym_len_n = 3'd0;
                        sym_pat_n = 5'd0;
                        ovf_n = 1'b0;
                    end
                    if (cnt_inc == WORD_GAP) begin
                        char_valid_n = 1'b1;
                        char_out_n = CH_SPACE;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            sym_len <= 3'd0;
            sym_pat <= 5'd0;
            ovf <= 1'b0;
            char_out <= 8'd0;
            char_valid <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sym_len <= sym_len_n;
            sym_pat <= sym_pat_n;
            ovf <= ovf_n;
            char_out <= char_out_n;
            char_valid <= char_valid_n;
            err <= err_n;
        end
    assign bus.char_out = char_out;
    assign bus.char_valid = char_valid;
    assign bus.err = err;
    assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: keys directed and random Morse traffic; a duration-based reference model
// queues expected characters and a monitor checks every char_valid/err strobe against them.
module tb_morse_decoder;
    localparam int U = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [8:0] exp_q[$];
    string pending = "";
    string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                           "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                           "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digits[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                          "---..", "----."};
    morse_decoder_if bus ();
    morse_decoder #(.UNIT_CYCLES(U), .MAX_SYMBOLS(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Expected {err, ascii} for a complete symbol string.
    function automatic logic [8:0] decode(string s);
        if (s.len() > 5) return {1'b1, 8'h3F};
        for (int i = 0; i < 26; i++) if (s == letters[i]) return {1'b0, 8'(65 + i)};
`ifdef MORSE_DIGITS_EN
        for (int i = 0; i < 10; i++) if (s == digits[i]) return {1'b0, 8'(48 + i)};
`endif
        return {1'b1, 8'h3F};
    endfunction

    task automatic hold(input logic v, input int n);
        bus.key_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One mark of m cycles followed by g low cycles; the model classifies by duration.
    task automatic key_mark(input int m, input int g);
        string sym;
        sym = (m < 2*U) ? "." : "-";
        pending = {pending, sym};
        if (g >= 2*U) begin
            exp_q.push_back(decode(pending));
            pending = "";
        end
        if (g >= 5*U) exp_q.push_back({1'b0, 8'h20});
        hold(1'b1, m);
        hold(1'b0, g);
    endtask

    task automatic send(input string code, input int gap, input bit rnd);
        for (int i = 0; i < code.len(); i++) begin
            int m, g;
            m = (code[i] == "-") ? (rnd ? $urandom_range(2*U, 5*U) : 3*U) : (rnd ? $urandom_range(1, 2*U-1) : U);
            g = (i == code.len() - 1) ? gap : (rnd ? $urandom_range(1, 2*U-1) : U);
            key_mark(m, g);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    always @(negedge clk)
        if (!rst && (bus.char_valid || bus.err)) begin
            vectors++;
            if (!bus.char_valid) begin
                miscompares++;
                $display("FAIL err_without_valid: err=1 char_valid=0");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_char: got err=%0b char=%h, expected no strobe", bus.err, bus.char_out);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({bus.err, bus.char_out} !== e) begin
                    miscompares++;
                    $display("FAIL char: got err=%0b char=%h, expected err=%0b char=%h", bus.err, bus.char_out, e[8], e[7:0]);
                end
            end
        end

    initial begin
        bus.key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {21'd0, bus.char_out, bus.char_valid, bus.err, bus.busy}, 32'd0);
        rst = 1'b0;
        hold(1'b0, 5);
        send("...", 12, 0);
        send("---", 12, 0);
        send("...", 12, 0);
        send("-..", 12, 0);
        send(".", 28, 0);
        check("busy_after_space", {31'd0, bus.busy}, 32'd0);
        hold(1'b0, 100);
        send("......", 12, 0);
        send(".", 12, 0);
        key_mark(7, 12);
        key_mark(8, 12);
        key_mark(4, 7);
        key_mark(4, 25);
        key_mark(12, 4);
        key_mark(12, 4);
        hold(1'b1, 6);
        rst = 1'b1;
        #1;
        check("reset_mid_char", {21'd0, bus.char_out, bus.char_valid, bus.err, bus.busy}, 32'd0);
        pending = "";
        bus.key_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 4);
        send("-----", 25, 0);
        repeat (40) begin
            string code;
            int sel, gap;
            sel = $urandom_range(0, 9);
            if (sel < 7) code = letters[$urandom_range(0, 25)];
            else if (sel < 9) code = digits[$urandom_range(0, 9)];
            else begin
                code = "";
                for (int i = 0; i < 6; i++) code = {code, ($urandom_range(0, 1) != 0) ? "-" : "."};
            end
            sel = $urandom_range(0, 5);
            gap = (sel == 0) ? $urandom_range(1, 2*U-1) : (sel < 4) ? $urandom_range(2*U, 5*U-1) : $urandom_range(5*U, 30);
            send(code, gap, 1);
        end
        send(".", 30, 1);
        hold(1'b0, 10);
        check("queue_drained", exp_q.size(), 32'd0);
        check("busy_at_end", {31'd0, bus.busy}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
